shiftout_word_seq: RTL and testbench
====================================

Name: shiftout_word_seq

Overview:
- Upstream controller for the 16-bit parallel-load serial-out shift register in the FEC front-end configuration path.
- Accepts a frame of N 16-bit words from a valid/ready source.
- Drives the shift register's sset, sload and svalue inputs, so the words leave MSB-first on its shiftout as one contiguous bit stream.
- Generates frame-valid, busy, done and underrun indications for the surrounding logic.

Parameters:
- WIDTH, 16, word width; must equal the shift register width.
- NW_W, 8, width of the frame word-count input.
- IDLE_HIGH, 1, 1 = hold sset while idle so the serial line idles at 1; 0 = line idles at 0 (sset never asserted).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset); same net as the shift register reset.
- start  in  1  one-cycle frame request; sampled only in IDLE.
- nwords  in  NW_W  words in frame; sampled with start.
- din  in  WIDTH  next word from source.
- din_valid  in  1  source has a word.
- din_ready  out  1  sequencer takes din this cycle when din_valid=1.
- sset  out  1  to shift register sset.
- sload  out  1  to shift register sload.
- svalue  out  WIDTH  to shift register svalue; combinational copy of din.
- sframe  out  1  registered; 1 in every cycle shiftout carries a frame bit.
- busy  out  1  registered; 1 from the cycle after accepted start until the last bit cycle.
- done  out  1  registered one-cycle pulse after the last frame bit.
- err_underrun  out  1  registered one-cycle pulse when a word was due but din_valid=0.

Behaviour:
- Reset (async, reset=0): state IDLE, counters 0. Outputs: din_ready=0, sload=0, sset=IDLE_HIGH, sframe=0, busy=0, done=0, err_underrun=0. Reset mid-frame aborts with no done pulse. The shift register clears with the same reset.
- States: IDLE, WAIT_WORD, SHIFT.
- Counters: bitcnt (4 bits, 0..15), wleft (NW_W bits).
- IDLE:
  - sset=IDLE_HIGH, sload=0, din_ready=0.
  - start=1 with nwords>0: wleft=nwords, go to WAIT_WORD.
  - start=1 with nwords=0: done pulse next cycle, stay IDLE.
- WAIT_WORD:
  - din_ready=1, sset=IDLE_HIGH.
  - sload = din_valid. sset and sload are never both 1; if sload=1, sset=0.
  - On accept: wleft-1, bitcnt=0, go to SHIFT.
- SHIFT:
  - sset=0. Default sload=0 (the shift register shifts left one bit per cycle).
  - bitcnt increments every cycle.
  - At bitcnt=15 with wleft>0: din_ready=1.
    - din_valid=1: sload=1, word accepted, wleft-1, bitcnt wraps to 0. Seamless; no gap between words.
    - din_valid=0: err_underrun pulse next cycle, go to WAIT_WORD. The line returns to idle level, and the frame resumes when a word arrives.
  - At bitcnt=15 with wleft=0: go to IDLE; done=1 in the next cycle.
- sframe: 1 in the cycle after each accepted load and held for 16 cycles. It is 0 during underrun gaps and in IDLE.
- busy: 1 in every non-IDLE state.
- start while busy is ignored; no queuing.
- Latency: start accepted at edge E0, din_valid held high:
  - din_ready=1 in cycle 1.
  - First bit on shiftout in cycle 2; sframe cycles 2..16N+1.
  - busy cycles 1..16N+1; done in cycle 16N+2.
- Width rule: wleft decrements only on accept, never below 0. nwords up to 2^NW_W-1 is supported.

Decomposition:
- Shared package shiftout_pkg:
  - WIDTH_DEF=16 and BITCNT_W=4 constants.
  - State enum {IDLE, WAIT_WORD, SHIFT}.
- One sub-module, shiftout_counter: holds bitcnt and wleft, with load/decrement/wrap controls, and flags last_bit (bitcnt=15) and last_word (wleft=0).
- The FSM and handshake stay in the top module.

Test Plan:
- Single word: start with nwords=1, din=16'hA5C3 valid → sload=1 in cycle 1; shiftout bits 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 in cycles 2..17; sframe=1 exactly cycles 2..17; done=1 in cycle 18.
- Back-to-back: nwords=3, words 16'hFFFF, 16'h0000, 16'h8001 always valid → 48 contiguous bits, sload in cycles 1, 17, 33, no sframe gap, done in cycle 50.
- Underrun: nwords=2, din_valid dropped at second word's due cycle (17) and restored at cycle 20 → err_underrun pulse cycle 18, sframe=0 and shiftout=1 (IDLE_HIGH) in cycles 18..20, second word bits in cycles 21..36, done in cycle 37.
- Edge cases: nwords=0 → done pulse next cycle, sload never asserted. start during busy → no effect on frame length or done count.
- Reset mid-frame: reset=0 at bit 7 of word 1 → all outputs at reset values immediately, no done pulse; new start afterwards runs a clean frame.
- IDLE_HIGH=0 build: sset never 1, shiftout=0 while idle and during underrun gaps.

Source files
------------

// File: rtl/shiftout_pkg.sv
// Shared constants and state encoding for the shift-register word sequencer.
package shiftout_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned BITCNT_W  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitWord,
    StShift
  } state_e;

endpackage

// File: rtl/shiftout_counter.sv
// Bit-position and words-remaining counters for the shift-out sequencer.
module shiftout_counter
  import shiftout_pkg::*;
#(
  parameter int unsigned NW_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            bit_clr_i,
  input  logic            bit_inc_i,
  input  logic            word_load_i,
  input  logic            word_dec_i,
  input  logic [NW_W-1:0] nwords_i,
  output logic            last_bit_o,
  output logic            last_word_o
);

  logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [NW_W-1:0]     wleft_q, wleft_d;

  always_comb begin
    bitcnt_d = bitcnt_q;
    if (bit_clr_i) begin
      bitcnt_d = '0;
    end else if (bit_inc_i) begin
      bitcnt_d = bitcnt_q + 1'b1;
    end

    wleft_d = wleft_q;
    if (word_load_i) begin
      wleft_d = nwords_i;
    end else if (word_dec_i && (wleft_q != '0)) begin
      // Saturate at zero so a stray decrement can never wrap the count.
      wleft_d = wleft_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitcnt_q <= '0;
      wleft_q  <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      wleft_q  <= wleft_d;
    end
  end

  assign last_bit_o  = &bitcnt_q;
  assign last_word_o = (wleft_q == '0);

endmodule

// File: rtl/shiftout_word_seq.sv
// Feeds a frame of words from a valid/ready source into a parallel-load serial-out
// shift register so they leave MSB-first as one contiguous stream.
module shiftout_word_seq
  import shiftout_pkg::*;
#(
  // Bit counter is BITCNT_W wide, so WIDTH must match a 16-bit shift register.
  parameter int unsigned WIDTH     = WIDTH_DEF,
  parameter int unsigned NW_W      = 8,
  parameter bit          IDLE_HIGH = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NW_W-1:0]  nwords,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sset,
  output logic             sload,
  output logic [WIDTH-1:0] svalue,
  output logic             sframe,
  output logic             busy,
  output logic             done,
  output logic             err_underrun
);

  state_e state_q, state_d;
  logic   sframe_q, busy_q, done_q, err_q;
  logic   done_d, err_d;
  logic   bit_clr, bit_inc, word_load, word_dec;
  logic   last_bit, last_word;

  shiftout_counter #(
    .NW_W (NW_W)
  ) u_counter (
    .clk         (clk),
    .reset       (reset),
    .bit_clr_i   (bit_clr),
    .bit_inc_i   (bit_inc),
    .word_load_i (word_load),
    .word_dec_i  (word_dec),
    .nwords_i    (nwords),
    .last_bit_o  (last_bit),
    .last_word_o (last_word)
  );

  always_comb begin
    state_d   = state_q;
    din_ready = 1'b0;
    sload     = 1'b0;
    sset      = IDLE_HIGH;
    bit_clr   = 1'b0;
    bit_inc   = 1'b0;
    word_load = 1'b0;
    word_dec  = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (nwords != '0) begin
            word_load = 1'b1;
            state_d   = StWaitWord;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StWaitWord: begin
        din_ready = 1'b1;
        if (din_valid) begin
          sload    = 1'b1;
          sset     = 1'b0;
          word_dec = 1'b1;
          bit_clr  = 1'b1;
          state_d  = StShift;
        end
      end

      StShift: begin
        sset    = 1'b0;
        bit_inc = 1'b1;
        if (last_bit) begin
          if (!last_word) begin
            din_ready = 1'b1;
            if (din_valid) begin
              sload    = 1'b1;
              word_dec = 1'b1;
              bit_clr  = 1'b1;
            end else begin
              // Park the line at idle level for the whole underrun gap.
              sset    = IDLE_HIGH;
              err_d   = 1'b1;
              state_d = StWaitWord;
            end
          end else begin
            sset    = IDLE_HIGH;
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // sframe/busy are registered copies of the next state, so they line up with the
  // cycles in which shiftout actually carries frame bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      sframe_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sframe_q <= (state_d == StShift);
      busy_q   <= (state_d != StIdle);
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign svalue       = din;
  assign sframe       = sframe_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_shiftout_word_seq.sv
// Bench for shiftout_word_seq: timeline model of loads/bits/done plus shift-register models.
module tb_shiftout_word_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NW_W  = 8;
  localparam int          RMAX  = 4300;
  localparam int          NOGAP = 100000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [NW_W-1:0]  nwords = '0;
  logic [WIDTH-1:0] din = '0;
  logic             din_valid = 1'b0;

  logic             din_ready, sset, sload, sframe, busy, done, err_underrun;
  logic [WIDTH-1:0] svalue;
  logic             lo_din_ready, lo_sset, lo_sload, lo_sframe, lo_busy, lo_done, lo_err;
  logic [WIDTH-1:0] lo_svalue;

  always #5 clk = ~clk;

  shiftout_word_seq #(.WIDTH(WIDTH), .NW_W(NW_W), .IDLE_HIGH(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .nwords(nwords), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .sset(sset), .sload(sload),
    .svalue(svalue), .sframe(sframe), .busy(busy), .done(done),
    .err_underrun(err_underrun)
  );

  shiftout_word_seq #(.WIDTH(WIDTH), .NW_W(NW_W), .IDLE_HIGH(1'b0)) dut_lo (
    .clk(clk), .reset(reset), .start(start), .nwords(nwords), .din(din),
    .din_valid(din_valid), .din_ready(lo_din_ready), .sset(lo_sset), .sload(lo_sload),
    .svalue(lo_svalue), .sframe(lo_sframe), .busy(lo_busy), .done(lo_done),
    .err_underrun(lo_err)
  );

  // Behavioural 16-bit parallel-load serial-out shift registers (MSB out).
  logic [WIDTH-1:0] sr_hi, sr_lo;
  logic             line_ok;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_hi <= '0; sr_lo <= '0; line_ok <= 1'b0;
    end else begin
      line_ok <= 1'b1;
      if (sset) sr_hi <= '1;
      else if (sload) sr_hi <= svalue;
      else sr_hi <= {sr_hi[WIDTH-2:0], 1'b0};
      if (lo_sset) sr_lo <= '1;
      else if (lo_sload) sr_lo <= lo_svalue;
      else sr_lo <= {sr_lo[WIDTH-2:0], 1'b0};
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected timeline, indexed by cycle relative to the start cycle.
  bit               e_ready[RMAX], e_sload[RMAX], e_sframe[RMAX], e_busy[RMAX];
  bit               e_done[RMAX], e_err[RMAX], e_bit[RMAX];
  logic [WIDTH-1:0] wtab[256];
  int               t0 = 0;
  int               plan_len = 0;
  int               gap_lo = NOGAP;
  int               gap_hi = NOGAP;

  function automatic bit src_valid(input int r);
    return !(r >= gap_lo && r < gap_hi);
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < RMAX; i++) begin
      e_ready[i] = 0; e_sload[i] = 0; e_sframe[i] = 0; e_busy[i] = 0;
      e_done[i] = 0; e_err[i] = 0; e_bit[i] = 0;
    end
    plan_len = 0;
  endtask

  // Word k loads at the first valid cycle at or after it falls due; its 16 bits follow.
  task automatic plan(input int n);
    int due, l;
    logic [WIDTH-1:0] w;
    clear_plan();
    if (n == 0) begin
      e_done[1] = 1; plan_len = 1;
      return;
    end
    due = 1;
    for (int k = 0; k < n; k++) begin
      l = due;
      while (!src_valid(l)) l++;
      if (k > 0 && l > due) e_err[due+1] = 1;
      for (int r = due; r <= l; r++) e_ready[r] = 1;
      e_sload[l] = 1;
      w = wtab[k];
      for (int j = 0; j < 16; j++) begin
        e_sframe[l+1+j] = 1;
        e_bit[l+1+j] = w[15-j];
      end
      due = l + 16;
    end
    for (int r = 1; r <= due; r++) e_busy[r] = 1;
    e_done[due+1] = 1;
    plan_len = due + 1;
  endtask

  // Observations gathered by the compare process for literal checks.
  bit               chk_en = 0;
  bit               acc = 0;
  int               done_r, err_r, first_sload_r, done_cnt, err_cnt, sload_cnt, sframe_cnt;
  logic [WIDTH-1:0] cap;

  task automatic clear_obs();
    done_r = -1; err_r = -1; first_sload_r = -1;
    done_cnt = 0; err_cnt = 0; sload_cnt = 0; sframe_cnt = 0; cap = '0;
  endtask

  always @(negedge clk) begin
    int r;
    bit er, esl, esf, eb, ed, ee, ebit;
    if (chk_en) begin
      r = cyc - t0;
      er = 0; esl = 0; esf = 0; eb = 0; ed = 0; ee = 0; ebit = 0;
      if (r >= 0 && r < RMAX) begin
        er = e_ready[r]; esl = e_sload[r]; esf = e_sframe[r]; eb = e_busy[r];
        ed = e_done[r]; ee = e_err[r]; ebit = e_bit[r];
      end
      chk("din_ready", din_ready, er);
      chk("sload", sload, esl);
      chk("sframe", sframe, esf);
      chk("busy", busy, eb);
      chk("done", done, ed);
      chk("err_underrun", err_underrun, ee);
      chk("svalue", svalue, din);
      chk("sset_sload_excl", sset & sload, 1'b0);
      if (!eb) chk("sset_idle", sset, 1'b1);
      chk("lo_din_ready", lo_din_ready, er);
      chk("lo_sload", lo_sload, esl);
      chk("lo_sframe", lo_sframe, esf);
      chk("lo_busy", lo_busy, eb);
      chk("lo_done", lo_done, ed);
      chk("lo_err", lo_err, ee);
      chk("lo_sset", lo_sset, 1'b0);
      if (line_ok) begin
        chk("shiftout", sr_hi[WIDTH-1], esf ? ebit : 1'b1);
        chk("lo_shiftout", sr_lo[WIDTH-1], esf ? ebit : 1'b0);
      end
      if (done) begin done_r = r; done_cnt++; end
      if (err_underrun) begin err_r = r; err_cnt++; end
      if (sload) begin
        sload_cnt++;
        if (first_sload_r < 0) first_sload_r = r;
      end
      if (sframe) begin sframe_cnt++; cap = {cap[WIDTH-2:0], sr_hi[WIDTH-1]}; end
    end
    acc = din_valid && din_ready;
  end

  int k_src = 0;

  task automatic drive_cycle(input int r, input int n, input int busy_r);
    if (acc) k_src++;
    start = (busy_r > 0 && r == busy_r);
    nwords = start ? NW_W'(7) : '0;
    din_valid = (k_src < n) && src_valid(r);
    din = (k_src < n && k_src < 256) ? wtab[k_src] : '0;
  endtask

  task automatic launch(input int n);
    @(posedge clk); #1;
    clear_obs();
    t0 = cyc;
    plan(n);
    k_src = 0;
    start = 1'b1;
    nwords = NW_W'(n);
    din_valid = 1'b0;
  endtask

  task automatic run_frame(input int n, input int glo, input int ghi, input int busy_r);
    gap_lo = glo; gap_hi = ghi;
    launch(n);
    for (int r = 1; r <= plan_len + 2; r++) begin
      @(posedge clk); #1;
      drive_cycle(r, n, busy_r);
    end
    start = 1'b0; din_valid = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_din_ready"}, din_ready, 1'b0);
    chk({tag, "_sload"}, sload, 1'b0);
    chk({tag, "_sset"}, sset, 1'b1);
    chk({tag, "_lo_sset"}, lo_sset, 1'b0);
    chk({tag, "_sframe"}, sframe, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err_underrun, 1'b0);
  endtask

  initial begin
    clear_plan();
    clear_obs();
    #2;
    check_reset_values("por");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    t0 = cyc;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);

    // Single word.
    wtab[0] = 16'hA5C3;
    run_frame(1, NOGAP, NOGAP, 0);
    chk("t1_first_sload", first_sload_r, 1);
    chk("t1_done_cycle", done_r, 18);
    chk("t1_bits", cap, 16'hA5C3);
    chk("t1_sframe_len", sframe_cnt, 16);

    // Back-to-back words with an ignored start while busy.
    wtab[0] = 16'hFFFF; wtab[1] = 16'h0000; wtab[2] = 16'h8001;
    run_frame(3, NOGAP, NOGAP, 5);
    chk("t2_done_cycle", done_r, 50);
    chk("t2_loads", sload_cnt, 3);
    chk("t2_sframe_len", sframe_cnt, 48);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_last_bits", cap, 16'h8001);

    // Underrun on the second word.
    wtab[0] = 16'h1234; wtab[1] = 16'hABCD;
    run_frame(2, 17, 20, 0);
    chk("t3_err_cycle", err_r, 18);
    chk("t3_done_cycle", done_r, 37);
    chk("t3_last_bits", cap, 16'hABCD);

    // Empty frame.
    run_frame(0, NOGAP, NOGAP, 0);
    chk("t4_done_cycle", done_r, 1);
    chk("t4_loads", sload_cnt, 0);

    // Late first word is a wait, not an underrun.
    wtab[0] = 16'h0F0F;
    run_frame(1, 1, 4, 0);
    chk("t5_done_cycle", done_r, 21);
    chk("t5_err_cnt", err_cnt, 0);

    // Reset in the middle of the first word.
    wtab[0] = 16'h5A5A; wtab[1] = 16'hC3C3;
    gap_lo = NOGAP; gap_hi = NOGAP;
    launch(2);
    for (int r = 1; r <= 10; r++) begin
      @(posedge clk); #1;
      drive_cycle(r, 2, 0);
    end
    #2;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_values("abort");
    start = 1'b0; din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    clear_plan();
    clear_obs();
    t0 = cyc;
    chk_en = 1'b1;
    repeat (20) @(posedge clk);
    chk("t6_no_done", done_cnt, 0);
    wtab[0] = 16'hA5C3;
    run_frame(1, NOGAP, NOGAP, 0);
    chk("t6_done_cycle", done_r, 18);
    chk("t6_bits", cap, 16'hA5C3);

    // Largest frame the count input can express.
    for (int k = 0; k < 256; k++) wtab[k] = {8'(k), ~8'(k)};
    run_frame(255, NOGAP, NOGAP, 0);
    chk("t7_done_cycle", done_r, 4082);
    chk("t7_sframe_len", sframe_cnt, 4080);
    chk("t7_last_bits", cap, 16'hFE01);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
